// File: rtl/adder_divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default data width,
// FSM state encoding and the iteration-counter width helper.
package adder_divider_seq_pkg;

    localparam int LEN_DATA_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter must hold 0..len, hence log2(len)+1 bits.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/adder_divider_seq_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude on a LEN_DATA+1 bit subtractor, keep the trial if no borrow.
module div_step
    import adder_divider_seq_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF
) (
    input  logic [LEN_DATA-1:0] rem_i,
    input  logic [LEN_DATA-1:0] quo_i,
    input  logic [LEN_DATA-1:0] dvs_i,
    output logic [LEN_DATA-1:0] rem_o,
    output logic [LEN_DATA-1:0] quo_o
);

    logic [LEN_DATA:0] shifted;
    logic [LEN_DATA:0] trial;
    logic [LEN_DATA:0] sel;
    logic              borrow;
    logic              sel_msb_unused;

    assign shifted = {rem_i, quo_i[LEN_DATA-1]};
    assign {borrow, trial} = {1'b0, shifted} - {2'b00, dvs_i};
    assign sel = borrow ? shifted : trial;

    // The kept partial remainder is always below the divisor, so its top bit is zero.
    assign rem_o          = sel[LEN_DATA-1:0];
    assign sel_msb_unused = sel[LEN_DATA];
    assign quo_o          = {quo_i[LEN_DATA-2:0], ~borrow};

endmodule

// File: rtl/adder_divider_seq.sv
// Sequential signed/unsigned restoring divider: one quotient bit per cycle,
// sign fix-up in a separate cycle, single-cycle divide-by-zero shortcut.
module adder_divider_seq
    import adder_divider_seq_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_signed,
    input  logic [LEN_DATA-1:0] dividend,
    input  logic [LEN_DATA-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [LEN_DATA-1:0] quotient,
    output logic [LEN_DATA-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = cnt_width(LEN_DATA);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_DATA-1:0] rem_q, rem_d;
    logic [LEN_DATA-1:0] quo_q, quo_d;
    logic [LEN_DATA-1:0] dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [LEN_DATA-1:0] quotient_q, quotient_d;
    logic [LEN_DATA-1:0] remainder_q, remainder_d;
    logic                dbz_q, dbz_d;

    logic                dvd_neg, dvs_neg;
    logic [LEN_DATA-1:0] dvd_mag, dvs_mag;
    logic [LEN_DATA-1:0] step_rem, step_quo;

    // Magnitudes of the incoming operands; most-negative maps to 2^(LEN_DATA-1) unsigned.
    assign dvd_neg = is_signed & dividend[LEN_DATA-1];
    assign dvs_neg = is_signed & divisor[LEN_DATA-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;

    div_step #(.LEN_DATA(LEN_DATA)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch behind.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        quo_d     = dvd_mag;
                        rem_d     = '0;
                        dvs_d     = dvs_mag;
                        cnt_d     = '0;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LEN_DATA - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_adder_divider_seq.sv
// Directed self-checking bench for adder_divider_seq at the default 64-bit width.
module tb_adder_divider_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_cmp;
    int n_err;
    int done_cnt;
    int lat;

    adder_divider_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives start for one sample edge, then waits for done.
    // lat counts edges from the sample edge (1) to the edge that raised done.
    // poke_at >= 0 re-pulses start (9/3) while the operation is running.
    task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                          input int poke_at, output int lat_o);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_o = 1;
        while (done !== 1'b1 && lat_o < 200) begin
            if (lat_o == poke_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                dividend  = 64'd9;
                divisor   = 64'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat_o++;
        end
        start = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #7;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quo",  quotient, 64'd0);
        check("rst_rem",  remainder, 64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 100/7
        @(negedge clk);
        run_op(1'b0, 64'd100, 64'd7, -1, lat);
        check("u100_7_lat", 64'(lat), 64'd66);
        check("u100_7_quo", quotient, 64'd14);
        check("u100_7_rem", remainder, 64'd2);
        check("u100_7_dbz", 64'(div_by_zero), 64'd0);
        check("u100_7_busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("u100_7_done_pulse", 64'(done), 64'd0);

        // Signed -100/7
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, -1, lat);
        check("sn100_7_lat", 64'(lat), 64'd66);
        check("sn100_7_quo", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
        check("sn100_7_rem", remainder, 64'hFFFF_FFFF_FFFF_FFFE);

        // Signed 100/-7
        @(negedge clk);
        run_op(1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, -1, lat);
        check("s100_n7_quo", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
        check("s100_n7_rem", remainder, 64'd2);

        // Unsigned divide by zero
        @(negedge clk);
        run_op(1'b0, 64'h1234, 64'd0, -1, lat);
        check("u_dbz_lat", 64'(lat), 64'd1);
        check("u_dbz_quo", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("u_dbz_rem", remainder, 64'h1234);
        check("u_dbz_flag", 64'(div_by_zero), 64'd1);

        // Signed divide by zero, then hold for several idle cycles
        @(negedge clk);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, -1, lat);
        check("s_dbz_lat", 64'(lat), 64'd1);
        check("s_dbz_quo", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("s_dbz_rem", remainder, 64'hFFFF_FFFF_FFFF_FFFB);
        repeat (5) @(negedge clk);
        check("hold_rem", remainder, 64'hFFFF_FFFF_FFFF_FFFB);
        check("hold_dbz", 64'(div_by_zero), 64'd1);
        check("hold_done", 64'(done), 64'd0);

        // Signed overflow: most-negative / -1
        run_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, -1, lat);
        check("ovf_lat", 64'(lat), 64'd66);
        check("ovf_quo", quotient, 64'h8000_0000_0000_0000);
        check("ovf_rem", remainder, 64'd0);
        check("ovf_dbz", 64'(div_by_zero), 64'd0);

        // Unsigned 2^63 / 3
        @(negedge clk);
        run_op(1'b0, 64'h8000_0000_0000_0000, 64'd3, -1, lat);
        check("u_big3_quo", quotient, 64'h2AAA_AAAA_AAAA_AAAA);
        check("u_big3_rem", remainder, 64'd2);

        // Same bit patterns as the overflow case but unsigned
        @(negedge clk);
        run_op(1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, -1, lat);
        check("u_bigmax_quo", quotient, 64'd0);
        check("u_bigmax_rem", remainder, 64'h8000_0000_0000_0000);

        // Start re-pulsed at cycle 10 of an operation, and again on the done cycle
        @(negedge clk);
        run_op(1'b0, 64'd100, 64'd7, 10, lat);
        check("poke_lat", 64'(lat), 64'd66);
        check("poke_quo", quotient, 64'd14);
        check("poke_rem", remainder, 64'd2);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 64'd9;
        divisor   = 64'd3;
        @(negedge clk);
        start = 1'b0;
        check("poke_done_busy", 64'(busy), 64'd0);
        check("poke_done_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("poke_done_idle", 64'(busy), 64'd0);
        check("poke_hold_quo", quotient, 64'd14);

        // Reset asserted mid-CALC, then a start in the first cycle after release
        is_signed = 1'b0;
        dividend  = 64'd100;
        divisor   = 64'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_quo",  quotient, 64'd0);
        check("abort_rem",  remainder, 64'd0);
        check("abort_dbz",  64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 64'd9, 64'd3, -1, lat);
        check("post_rst_lat", 64'(lat), 64'd66);
        check("post_rst_quo", quotient, 64'd3);
        check("post_rst_rem", remainder, 64'd0);

        // One done per completed operation, none from the aborted one
        repeat (3) @(negedge clk);
        check("done_pulse_count", 64'(done_cnt), 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
